// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles,
// LSB first, with a registered carry. Result held in S/C between completions.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d, c_q, c_d;

    logic             sum_bit, cout;
    logic [WIDTH-1:0] acc_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        cy_d      = cy_q;
        c_d       = c_q;
        sum_bit   = a_q[0] ^ b_q[0] ^ cy_q;
        cout      = (a_q[0] & b_q[0]) | (cy_q & (a_q[0] ^ b_q[0]));
        // Sum bits enter at the top so the LSB reaches bit 0 after WIDTH shifts.
        acc_shift = acc_q >> 1;
        acc_shift[WIDTH-1] = sum_bit;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    // Subtract is add of ~B with inverted borrow-in.
                    b_d     = B ^ {WIDTH{SUB}};
                    cy_d    = Cin ^ SUB;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cy_d  = cout;
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    s_d     = acc_shift;
                    c_d     = cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign C    = c_q;

endmodule
